// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file write-back constants and request record
//   RF_AW    - register address width
//   RF_DW    - nominal register data width
//   RF_ZERO  - hard-wired zero register, never written
//   wr_req_t - one write-back request {valid, waddr, wdata}
package regfile_pkg;
    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam logic [RF_AW-1:0] RF_ZERO = 5'd0;
    typedef struct packed {
        logic             valid;
        logic [RF_AW-1:0] waddr;
        logic [RF_DW-1:0] wdata;
    } wr_req_t;
endpackage

// File: rtl/regfile_wb_arb_rr_pick.sv
// rr_pick: combinational round-robin picker
//   valid - request vector, N bits
//   ptr   - index of the last winner; search starts at ptr+1 modulo N
//   grant - one-hot winner, zero when nothing is valid
//   idx   - binary index of the winner
//   any   - at least one request is valid
module rr_pick import regfile_pkg::*; #(
    parameter int N = 3
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] j;
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = ptr;
        for (int k = 0; k < N; k++) begin
            j = (j == IW'(N - 1)) ? '0 : j + 1'b1;
            if (!any && valid[j]) begin
                grant[j] = 1'b1;
                idx      = j;
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: round-robin arbiter merging NREQ write-back requesters onto one register-file write port
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   en        - grant enable, 0 freezes arbitration
//   req_valid - per-requester write request
//   req_waddr - per-requester destination register, 5 bits each
//   req_wdata - per-requester write data, DW bits each
//   req_ready - per-requester grant, one-hot or zero
//   rf_we     - registered write enable, never set for register 0
//   rf_waddr  - registered write address
//   rf_wdata  - registered write data
//   stall_cnt - saturating count of cycles with ungranted requests
//               (present only with REGFILE_WB_ARB_STALL_CNT_EN defined)
module regfile_wb_arb import regfile_pkg::*; #(
    parameter int NREQ = 3,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*RF_AW-1:0] req_waddr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_we,
    output logic [RF_AW-1:0]     rf_waddr,
    output logic [DW-1:0]        rf_wdata
`ifdef REGFILE_WB_ARB_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);
    localparam int IW = $clog2(NREQ);
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    idx;
    logic [NREQ-1:0]  grant;
    logic             any;
    logic             xfer;
    logic [RF_AW-1:0] wa [NREQ];
    logic [DW-1:0]    wd [NREQ];
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            wa[i] = req_waddr[i*RF_AW +: RF_AW];
            wd[i] = req_wdata[i*DW +: DW];
        end
    end
    rr_pick #(.N(NREQ)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );
    // Grants are withheld while reset is asserted so no transfer can be accepted then.
    assign xfer      = en && rst && any;
    assign req_ready = xfer ? grant : '0;
    // ptr starts at the last index so requester 0 wins first after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= IW'(NREQ - 1);
            rf_we    <= 1'b0;
            rf_waddr <= RF_ZERO;
            rf_wdata <= '0;
        end else begin
            rf_we <= xfer && (wa[idx] != RF_ZERO);
            if (xfer) begin
                ptr      <= idx;
                rf_waddr <= wa[idx];
                rf_wdata <= wd[idx];
            end
        end
    end
`ifdef REGFILE_WB_ARB_STALL_CNT_EN
    logic stall;
    assign stall = |(req_valid & ~req_ready);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arb.sv
// tb_regfile_wb_arb: self-checking bench for regfile_wb_arb (NREQ=3, DW=32)
module tb_regfile_wb_arb;
    localparam int N  = 3;
    localparam int DW = 32;
    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en  = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*5-1:0]  req_waddr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [DW-1:0]   rf_wdata;
`ifdef REGFILE_WB_ARB_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif
    regfile_wb_arb #(.NREQ(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_waddr (req_waddr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
`ifdef REGFILE_WB_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );
    always #5 clk = ~clk;
    int checks   = 0;
    int failures = 0;
    int          m_ptr;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          m_stall;
    typedef struct {
        logic        e;
        logic [2:0]  v;
        logic [14:0] wa;
        logic [2:0]  er;
        logic        ew;
    } vec_t;
    vec_t tbl [8];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Reference rule: first valid requester found walking upward from last winner + 1.
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction
    // Called at posedge+1; leaves time at posedge+1 with reset released.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_ready", {29'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        m_ptr   = N - 1;
        m_we    = 1'b0;
        m_wa    = '0;
        m_wd    = '0;
        m_stall = 0;
    endtask
    task automatic step(input logic e, input logic [N-1:0] v, input logic [N*5-1:0] wa,
                        input logic [N*DW-1:0] wd, output logic [N-1:0] rdy);
        int g;
        logic [N-1:0] exp;
        en = e; req_valid = v; req_waddr = wa; req_wdata = wd;
        #1;
        g   = e ? pick(v, m_ptr) : -1;
        exp = (g >= 0) ? N'(1) << g : '0;
        chk("ready", {29'd0, req_ready}, {29'd0, exp});
        rdy = req_ready;
        if ((v & ~exp) != 0 && m_stall < 65535) m_stall++;
        if (g >= 0) begin
            m_ptr = g;
            m_wa  = wa[g*5 +: 5];
            m_wd  = wd[g*DW +: DW];
            m_we  = (m_wa != 5'd0);
        end else
            m_we = 1'b0;
        @(posedge clk);
        #1;
        chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
        chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_wa});
        chk("rf_wdata", rf_wdata, m_wd);
`ifdef REGFILE_WB_ARB_STALL_CNT_EN
        chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
    endtask
    function automatic logic [N*DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction
    initial begin
        logic [N-1:0] r;
        logic [N*DW-1:0] d;
        tbl[0] = '{1'b1, 3'b001, {5'd7, 5'd6, 5'd5}, 3'b001, 1'b1};
        tbl[1] = '{1'b1, 3'b101, {5'd7, 5'd6, 5'd5}, 3'b100, 1'b1};
        tbl[2] = '{1'b1, 3'b011, {5'd7, 5'd6, 5'd5}, 3'b001, 1'b1};
        tbl[3] = '{1'b0, 3'b111, {5'd7, 5'd6, 5'd5}, 3'b000, 1'b0};
        tbl[4] = '{1'b1, 3'b000, {5'd7, 5'd6, 5'd5}, 3'b000, 1'b0};
        tbl[5] = '{1'b1, 3'b110, {5'd7, 5'd6, 5'd5}, 3'b010, 1'b1};
        tbl[6] = '{1'b1, 3'b010, {5'd7, 5'd0, 5'd5}, 3'b010, 1'b0};
        tbl[7] = '{1'b1, 3'b011, {5'd7, 5'd6, 5'd5}, 3'b001, 1'b1};
        @(posedge clk);
        #1;
        req_valid = 3'b111;
        en = 1'b1;
        do_reset();
        // single request, same-cycle ready, one-cycle write latency
        d = {64'd0, 32'hDEADBEEF};
        step(1'b1, 3'b001, {10'd0, 5'd5}, d, r);
        chk("single_ready", {29'd0, r}, 32'd1);
        chk("single_we", {31'd0, rf_we}, 32'd1);
        chk("single_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        // directed table, fresh pointer
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].e, tbl[i].v, tbl[i].wa, rnd_data(), r);
            chk($sformatf("tbl%0d_ready", i), {29'd0, r}, {29'd0, tbl[i].er});
            chk($sformatf("tbl%0d_we", i), {31'd0, rf_we}, {31'd0, tbl[i].ew});
        end
        // all requesters held valid: strict rotation from requester 0
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, rnd_data(), r);
            chk($sformatf("order%0d", i), {29'd0, r}, 32'd1 << (i % 3));
        end
        // enable gating
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 3'b100, {5'd9, 5'd8, 5'd7}, rnd_data(), r);
        chk("gate_ready", {29'd0, r}, 32'd0);
`ifdef REGFILE_WB_ARB_STALL_CNT_EN
        chk("gate_stall", {16'd0, stall_cnt}, 32'd3);
`endif
        step(1'b1, 3'b100, {5'd9, 5'd8, 5'd7}, rnd_data(), r);
        chk("gate_grant", {29'd0, r}, 32'b100);
        // reset mid-transfer
        step(1'b1, 3'b001, {5'd9, 5'd8, 5'd7}, rnd_data(), r);
        chk("mid_we_before", {31'd0, rf_we}, 32'd1);
        en = 1'b1; req_valid = 3'b010;
        #1;
        chk("mid_ready", {29'd0, req_ready}, 32'b010);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_we_async", {31'd0, rf_we}, 32'd0);
        chk("mid_ready_rst", {29'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("mid_we_dropped", {31'd0, rf_we}, 32'd0);
        chk("mid_waddr_dropped", {27'd0, rf_waddr}, 32'd0);
        rst = 1'b1;
        m_ptr = N - 1; m_we = 1'b0; m_wa = '0; m_wd = '0; m_stall = 0;
        step(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, rnd_data(), r);
        chk("mid_first_prio", {29'd0, r}, 32'd1);
        // randomized against the reference model
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, N'($urandom), (N*5)'($urandom), rnd_data(), r);
`ifdef REGFILE_WB_ARB_STALL_CNT_EN
        do_reset();
        en = 1'b0; req_valid = 3'b001;
        repeat (70000) @(posedge clk);
        #1;
        chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
